// File: rtl/instr_encoder.sv
// MIPS instruction encoder: validates a request, packs R/I/J fields,
// and queues the encoded words in a small FIFO with a registered head.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_fmt,
  input  logic [5:0]               req_op,
  input  logic [4:0]               req_rs,
  input  logic [4:0]               req_rt,
  input  logic [4:0]               req_rd,
  input  logic [4:0]               req_shamt,
  input  logic [25:0]              req_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     err,
  output logic [7:0]               err_code,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              enc_count
);

  localparam int AW = $clog2(DEPTH);

  logic        sup;
  logic [31:0] word;

  always_comb begin
    sup  = 1'b0;
    word = '0;
    unique case (req_fmt)
      2'd0: begin
        unique case (req_op)
          6'h00, 6'h02, 6'h03: begin
            sup  = 1'b1;
            word = {6'd0, req_rs, req_rt, req_rd,
                    req_shamt, req_op};
          end
          6'h08: begin
            sup  = 1'b1;
            word = {6'd0, req_rs, 15'd0, req_op};
          end
          6'h04, 6'h06, 6'h18, 6'h1A,
          6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A: begin
            sup  = 1'b1;
            word = {6'd0, req_rs, req_rt, req_rd,
                    5'd0, req_op};
          end
          default: ;
        endcase
      end
      2'd1: begin
        unique case (req_op)
          6'h04, 6'h05, 6'h06, 6'h07,
          6'h08, 6'h09, 6'h0A, 6'h0C,
          6'h0D, 6'h0E, 6'h0F, 6'h20,
          6'h23, 6'h28, 6'h2B: begin
            sup  = 1'b1;
            word = {req_op, req_rs, req_rt,
                    req_imm[15:0]};
          end
          default: ;
        endcase
      end
      2'd2: begin
        unique case (req_op)
          6'h02, 6'h03: begin
            sup  = 1'b1;
            word = {req_op, req_imm};
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [7:0]    code_q, code_d;
  logic [31:0]   mem_q [DEPTH];
  logic          push, pop, rej;

  // Rejected requests never occupy a slot, so they are taken even when full.
  assign req_ready = !lvl_q[AW] || out_ready || !sup;
  assign pop       = (lvl_q != '0) && out_ready;
  assign push      = req_valid && req_ready && sup;
  assign rej       = req_valid && !sup;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    lvl_d  = lvl_q;
    cnt_d  = cnt_q;
    err_d  = rej;
    code_d = code_q;
    if (push) begin
      wr_d  = wr_q + AW'(1);
      cnt_d = cnt_q + 16'd1;
    end
    if (pop) rd_d = rd_q + AW'(1);
    if (rej) code_d = {req_fmt, req_op};
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + (AW+1)'(1);
      2'b01:   lvl_d = lvl_q - (AW+1)'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      code_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= word;
  end

  assign out_valid = (lvl_q != '0);
  assign out_instr = out_valid ? mem_q[rd_q] : '0;
  assign err       = err_q;
  assign err_code  = code_q;
  assign level     = lvl_q;
  assign enc_count = cnt_q;

endmodule
